mux_rr_sel: RTL and testbench
=============================

Name: mux_rr_sel

Overview:
- Parametrised, registered N:1 channel selector for the radix-4 datapath.
- Generalises the combinational 8:1 bit mux in three ways:
  - channels are W bits wide;
  - a valid/ready output stage is added;
  - a round-robin scan mode walks the enabled channels automatically.
- Sits between the partial-product generators and the downstream accumulator, serialising channels onto one W-bit bus.

Parameters:
- NCH, 8, number of input channels (≥2; need not be a power of 2).
- W, 1, width of each channel in bits.
- SELW, $clog2(NCH), select width. Localparam, derived; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a  in  NCH*W  packed channel data; channel k = a[k*W +: W].
- mode  in  1  0 = FIXED (use sel), 1 = SCAN (round-robin over en).
- sel  in  SELW  channel index in FIXED mode.
- en  in  NCH  channel enable mask, used in SCAN mode only.
- in_valid  in  1  request to capture one channel this cycle.
- in_ready  out  1  combinational; the capture is accepted when in_valid && in_ready.
- out  out  W  registered selected data.
- out_sel  out  SELW  registered index of the channel held in out.
- out_err  out  1  registered; set when a FIXED capture used sel ≥ NCH.
- out_valid  out  1  output register holds data.
- out_ready  in  1  downstream consumes when out_valid && out_ready.

Behaviour:
- Reset (async assert, sync release): out=0, out_sel=0, out_err=0, out_valid=0, scan pointer ptr=NCH-1. With ptr=NCH-1, the first SCAN grant goes to the lowest enabled channel.
- Single-entry output register; latency is 1 cycle from accepted capture to out_valid.
- in_ready = (!out_valid || out_ready) && !(mode==SCAN && en==0).
  - Back-to-back capture while draining is allowed: full throughput when out_ready is held high.
- Capture (in_valid && in_ready): a, sel, en and mode are sampled in that cycle. Then:
  - FIXED, sel < NCH: out ← channel sel; out_sel ← sel; out_err ← 0.
  - FIXED, sel ≥ NCH: out ← 0; out_sel ← sel; out_err ← 1.
  - SCAN: g = first enabled index strictly after ptr, searching cyclically (wrap NCH-1 → 0).
    - out ← channel g; out_sel ← g; out_err ← 0; ptr ← g.
    - If only ptr itself is enabled, g = ptr.
  - out_valid ← 1.
- Drain without capture (out_valid && out_ready && !(in_valid && in_ready)): out_valid ← 0. out, out_sel and out_err hold their last values.
- Stall (out_valid && !out_ready): out, out_sel, out_err and out_valid are held stable. in_ready=0. ptr does not advance.
- ptr is updated only by SCAN captures. FIXED captures and mode changes leave ptr unchanged, so SCAN resumes where it stopped.
- Changes to en between captures take effect at the next capture. An in-flight output is never altered.
- Reset asserted mid-operation: all state returns to reset values immediately; any held output is discarded.
- No X propagation: a, sel and en are sampled only on capture.

Decomposition:
- Shared package mux_pkg holds:
  - mode encodings MODE_FIXED=1'b0, MODE_SCAN=1'b1;
  - helper function for the select width.
- One natural sub-module: rr_next_sel.
  - Purely combinational.
  - Parameter NCH; inputs ptr and en; outputs g and any_en.
  - Implemented as a rotate, priority-encode, un-rotate of the mask.
- The top level holds the output register, handshake and ptr.

Test Plan:
- Reset then FIXED, NCH=8, W=4, a=32'h76543210, sel=5, in_valid pulse, out_ready=1 → next cycle out=4'h5, out_sel=5, out_valid=1, out_err=0; cycle after that, out_valid=0.
- SCAN, en=8'b1010_0101, in_valid held high, out_ready=1 → out_sel sequence 0,2,5,7,0,2,… with one capture per cycle; out equals the matching nibble each time.
- Backpressure: SCAN, en=8'hFF, out_ready=0 for 3 cycles after the first capture → out_sel=0 held stable, in_ready=0; after out_ready rises, the next value is out_sel=1 (no skip, no repeat).
- Boundary: NCH=6 build, FIXED sel=7 → out=0, out_sel=7, out_err=1. Also SCAN with en=0 → in_ready=0 and out_valid stays 0.
- Mode interleave: SCAN grants 0 and 1, then FIXED sel=4, then SCAN again with en=8'hFF → grants 0,1,4,2 (ptr unaffected by the FIXED capture).
- Async reset asserted mid-stream with out_valid=1 → out_valid=0 and out=0 without a clock edge; the first SCAN after release grants the lowest enabled channel.

Source files
------------

// File: rtl/mux_rr_sel_pkg.sv
// Shared encodings and helpers for the round-robin channel selector.
// Holds the mode encodings and the select-width helper used by every file of the block.
// No ports: this file contains a package only.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_SCAN  = 1'b1;

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_sel_if.sv
// Handshake bundle between the channel source, the selector and the accumulator.
// Ports: a/mode/sel/en/in_valid/out_ready are driven by the master side; in_ready,
// out/out_sel/out_err/out_valid are driven by the selector (slave side).
interface mux_rr_sel_if
    import mux_pkg::*;
#(
    parameter int NCH = 8,
    parameter int W   = 1
);
    localparam int SELW = sel_width(NCH);

    logic [NCH*W-1:0] a;
    logic             mode;
    logic [SELW-1:0]  sel;
    logic [NCH-1:0]   en;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     out;
    logic [SELW-1:0]  out_sel;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, mode, sel, en, in_valid, out_ready,
        input  in_ready, out, out_sel, out_err, out_valid
    );

    modport slave (
        input  a, mode, sel, en, in_valid, out_ready,
        output in_ready, out, out_sel, out_err, out_valid
    );

endinterface

// File: rtl/mux_rr_sel_rr_next_sel.sv
// Round-robin grant finder: first enabled channel strictly after ptr, cyclically.
// Ports: ptr (last grant), en (enable mask) in; g (next grant), any_en (mask non-empty) out.
// Purely combinational; NCH need not be a power of two.
module rr_next_sel
    import mux_pkg::*;
#(
    parameter  int NCH  = 8,
    localparam int SELW = sel_width(NCH)
) (
    input  logic [SELW-1:0] ptr,
    input  logic [NCH-1:0]  en,
    output logic [SELW-1:0] g,
    output logic            any_en
);

    logic [2*NCH-1:0] dbl;
    logic [2*NCH-1:0] shifted;
    logic [NCH-1:0]   rot;
    int               idx;
    int               sum;

    always_comb begin
        // Rotate so that bit 0 of rot is the channel just after ptr; the doubled
        // mask makes the rotate work for any NCH, not only powers of two.
        dbl     = {en, en};
        shifted = dbl >> (int'(ptr) + 1);
        rot     = shifted[NCH-1:0];

        // Priority-encode the lowest set bit of the rotated mask.
        idx = 0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                idx = j;
            end
        end

        // Un-rotate back to an absolute channel index (sum < 2*NCH).
        sum = int'(ptr) + 1 + idx;
        if (sum >= NCH) begin
            sum = sum - NCH;
        end
        g      = SELW'(sum);
        any_en = |en;
    end

endmodule

// File: rtl/mux_rr_sel.sv
// Registered N:1 channel selector, FIXED (sel) or SCAN (round-robin over en) mode.
// Ports: clk, rst_n (async active-low), bus (slave modport of mux_rr_sel_if).
// One-cycle capture-to-out_valid latency; in_ready drops only while the held output stalls
// or when SCAN has no enabled channel; full throughput with out_ready held high.
module mux_rr_sel
    import mux_pkg::*;
#(
    parameter int NCH = 8,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_rr_sel_if.slave  bus
);

    localparam int SELW = sel_width(NCH);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] g;
    logic            any_en;
    logic            scan_mode;
    logic            cap;

    logic [W-1:0]    fix_dat;
    logic            sel_ok;
    logic [W-1:0]    scan_dat;

    logic [W-1:0]    out_q;
    logic [SELW-1:0] out_sel_q;
    logic            out_err_q;
    logic            out_valid_q;

    rr_next_sel #(.NCH(NCH)) u_rr_next_sel (
        .ptr    (ptr),
        .en     (bus.en),
        .g      (g),
        .any_en (any_en)
    );

    assign scan_mode    = (bus.mode == MODE_SCAN);
    // SCAN with an empty mask has nothing to grant, so refuse the capture.
    assign bus.in_ready = (!out_valid_q || bus.out_ready) && !(scan_mode && !any_en);
    assign cap          = bus.in_valid && bus.in_ready;

    // Equality scan over legal indices: an out-of-range sel simply matches nothing.
    always_comb begin
        fix_dat  = '0;
        sel_ok   = 1'b0;
        scan_dat = '0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.sel == SELW'(k)) begin
                fix_dat = bus.a[k*W +: W];
                sel_ok  = 1'b1;
            end
            if (g == SELW'(k)) begin
                scan_dat = bus.a[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_sel_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            // Starting at the last index makes the first SCAN grant the lowest enabled channel.
            ptr         <= SELW'(NCH - 1);
        end else if (cap) begin
            out_valid_q <= 1'b1;
            if (scan_mode) begin
                out_q     <= scan_dat;
                out_sel_q <= g;
                out_err_q <= 1'b0;
                ptr       <= g;
            end else begin
                out_q     <= sel_ok ? fix_dat : '0;
                out_sel_q <= bus.sel;
                out_err_q <= !sel_ok;
            end
        end else if (out_valid_q && bus.out_ready) begin
            // Drain: data fields keep their last values, only the valid flag drops.
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_sel.sv
module tb_mux_rr_sel;
    import mux_pkg::*;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    mux_rr_sel_if #(.NCH(8), .W(4)) b8 ();
    mux_rr_sel_if #(.NCH(6), .W(4)) b6 ();

    mux_rr_sel #(.NCH(8), .W(4)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    mux_rr_sel #(.NCH(6), .W(4)) u6 (.clk(clk), .rst_n(rst_n), .bus(b6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b8.a = 32'h76543210; b8.mode = MODE_FIXED; b8.sel = '0; b8.en = '0;
        b8.in_valid = 1'b0; b8.out_ready = 1'b1;
        b6.a = 24'h543210; b6.mode = MODE_FIXED; b6.sel = '0; b6.en = '0;
        b6.in_valid = 1'b0; b6.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_total++; if (b8.out !== 4'h0) $display("FAIL reset_out got=%h exp=0", b8.out); else n_pass++;
        n_total++; if (b8.out_sel !== 3'd0) $display("FAIL reset_out_sel got=%0d exp=0", b8.out_sel); else n_pass++;
        n_total++; if (b8.out_err !== 1'b0) $display("FAIL reset_out_err got=%b exp=0", b8.out_err); else n_pass++;
        n_total++; if (b8.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", b8.out_valid); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fixed();
        b8.mode = MODE_FIXED; b8.sel = 3'd5; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        #1;
        n_total++; if (b8.in_ready !== 1'b1) $display("FAIL fixed_in_ready got=%b exp=1", b8.in_ready); else n_pass++;
        step();
        b8.in_valid = 1'b0;
        n_total++; if (b8.out !== 4'h5) $display("FAIL fixed_out got=%h exp=5", b8.out); else n_pass++;
        n_total++; if (b8.out_sel !== 3'd5) $display("FAIL fixed_out_sel got=%0d exp=5", b8.out_sel); else n_pass++;
        n_total++; if (b8.out_valid !== 1'b1) $display("FAIL fixed_out_valid got=%b exp=1", b8.out_valid); else n_pass++;
        n_total++; if (b8.out_err !== 1'b0) $display("FAIL fixed_out_err got=%b exp=0", b8.out_err); else n_pass++;
        step();
        n_total++; if (b8.out_valid !== 1'b0) $display("FAIL fixed_drain_valid got=%b exp=0", b8.out_valid); else n_pass++;
        n_total++; if (b8.out !== 4'h5) $display("FAIL fixed_drain_hold got=%h exp=5", b8.out); else n_pass++;
    endtask

    task automatic test_scan();
        logic [2:0] exp_seq [6];
        exp_seq = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd2};
        b8.mode = MODE_SCAN; b8.en = 8'b1010_0101; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_total++;
            if (b8.out_sel !== exp_seq[i] || b8.out !== {1'b0, exp_seq[i]} || b8.out_valid !== 1'b1)
                $display("FAIL scan_seq[%0d] got sel=%0d out=%h vld=%b exp sel=%0d out=%h vld=1",
                         i, b8.out_sel, b8.out, b8.out_valid, exp_seq[i], {1'b0, exp_seq[i]});
            else n_pass++;
        end
        b8.in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        b8.mode = MODE_SCAN; b8.en = 8'hFF; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
        step();
        n_total++; if (b8.out_sel !== 3'd0 || b8.out_valid !== 1'b1)
            $display("FAIL bp_first got sel=%0d vld=%b exp sel=0 vld=1", b8.out_sel, b8.out_valid); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (b8.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, b8.in_ready); else n_pass++;
            step();
            n_total++; if (b8.out_sel !== 3'd0 || b8.out !== 4'h0 || b8.out_valid !== 1'b1)
                $display("FAIL bp_hold[%0d] got sel=%0d out=%h vld=%b exp sel=0 out=0 vld=1",
                         i, b8.out_sel, b8.out, b8.out_valid); else n_pass++;
        end
        b8.out_ready = 1'b1;
        #1;
        n_total++; if (b8.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%b exp=1", b8.in_ready); else n_pass++;
        step();
        b8.in_valid = 1'b0;
        n_total++; if (b8.out_sel !== 3'd1 || b8.out !== 4'h1)
            $display("FAIL bp_next got sel=%0d out=%h exp sel=1 out=1", b8.out_sel, b8.out); else n_pass++;
        step();
        n_total++; if (b8.out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", b8.out_valid); else n_pass++;
    endtask

    task automatic test_boundary();
        b6.mode = MODE_FIXED; b6.sel = 3'd7; b6.in_valid = 1'b1; b6.out_ready = 1'b1;
        step();
        n_total++; if (b6.out !== 4'h0 || b6.out_sel !== 3'd7 || b6.out_err !== 1'b1)
            $display("FAIL n6_sel7 got out=%h sel=%0d err=%b exp out=0 sel=7 err=1",
                     b6.out, b6.out_sel, b6.out_err); else n_pass++;
        b6.sel = 3'd3;
        step();
        b6.in_valid = 1'b0;
        n_total++; if (b6.out !== 4'h3 || b6.out_sel !== 3'd3 || b6.out_err !== 1'b0)
            $display("FAIL n6_sel3 got out=%h sel=%0d err=%b exp out=3 sel=3 err=0",
                     b6.out, b6.out_sel, b6.out_err); else n_pass++;
        b8.mode = MODE_SCAN; b8.en = 8'h00; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        #1;
        n_total++; if (b8.in_ready !== 1'b0) $display("FAIL scan_en0_in_ready got=%b exp=0", b8.in_ready); else n_pass++;
        step();
        step();
        n_total++; if (b8.out_valid !== 1'b0) $display("FAIL scan_en0_valid got=%b exp=0", b8.out_valid); else n_pass++;
        b8.in_valid = 1'b0;
    endtask

    task automatic test_mode_interleave();
        logic [2:0] exp_seq [5];
        exp_seq = '{3'd0, 3'd1, 3'd4, 3'd2, 3'd3};
        do_reset();
        b8.en = 8'hFF; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b8.mode = (i == 2) ? MODE_FIXED : MODE_SCAN;
            b8.sel  = 3'd4;
            step();
            n_total++;
            if (b8.out_sel !== exp_seq[i] || b8.out !== {1'b0, exp_seq[i]})
                $display("FAIL interleave[%0d] got sel=%0d out=%h exp sel=%0d out=%h",
                         i, b8.out_sel, b8.out, exp_seq[i], {1'b0, exp_seq[i]});
            else n_pass++;
        end
        b8.in_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        b8.mode = MODE_SCAN; b8.en = 8'b0100_0000; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
        step();
        b8.in_valid = 1'b0;
        n_total++; if (b8.out_valid !== 1'b1 || b8.out !== 4'h6)
            $display("FAIL areset_pre got vld=%b out=%h exp vld=1 out=6", b8.out_valid, b8.out); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (b8.out_valid !== 1'b0 || b8.out !== 4'h0 || b8.out_sel !== 3'd0)
            $display("FAIL areset_now got vld=%b out=%h sel=%0d exp vld=0 out=0 sel=0",
                     b8.out_valid, b8.out, b8.out_sel); else n_pass++;
        step();
        #2;
        rst_n = 1'b1;
        step();
        b8.en = 8'b0011_0000; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        step();
        b8.in_valid = 1'b0;
        n_total++; if (b8.out_sel !== 3'd4 || b8.out !== 4'h4 || b8.out_valid !== 1'b1)
            $display("FAIL areset_first_scan got sel=%0d out=%h vld=%b exp sel=4 out=4 vld=1",
                     b8.out_sel, b8.out, b8.out_valid); else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b1;
        idle_inputs();
        #3;
        test_reset();
        test_fixed();
        test_scan();
        test_backpressure();
        test_boundary();
        test_mode_interleave();
        test_async_reset();
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
